stack_alu_sequencer: RTL
========================

Name: stack_alu_sequencer

Overview:
Program-driven controller for the stack-based ALU. It buffers a short RPN program of push/add/mul/pop instructions from an upstream requester, then issues them to the ALU one at a time. It tracks stack occupancy, so underflow and stack-full conditions are caught before they reach the ALU. It also returns the final ALU result with sticky overflow over a valid/ready handshake.

Parameters:
N, 8, ALU data width (matches ALU n)
PROG_DEPTH, 8, instruction buffer entries (power of 2, >=2)
STACK_DEPTH, 16, ALU stack capacity used for full checks
ALU_LAT, 1, cycles from opcode issue to valid ALU output_data/overflow (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  upstream instruction valid
instr_ready  out  1  sequencer can accept instruction
instr_opcode  in  3  100 add, 101 mul, 110 push, 111 pop; others illegal
instr_data  in  N  push operand (ignored for other opcodes)
instr_last  in  1  marks final instruction of program
result_valid  out  1  result available
result_ready  in  1  downstream accepts result
result_data  out  N  last captured ALU output_data
result_overflow  out  1  OR of alu_overflow over the program's add/mul ops
busy  out  1  high in EXEC/CAPTURE
error  out  1  sticky error
error_code  out  2  00 none, 01 illegal opcode, 10 underflow, 11 stack full
err_clr  in  1  clears error, returns to LOAD
alu_opcode  out  3  to ALU; 000 = no-op when idle
alu_input_data  out  N  to ALU input_data
alu_output_data  in  N  from ALU
alu_overflow  in  1  from ALU

Behaviour:
- Reset (async, any state): state=LOAD. Pointers=0, depth=0. All outputs 0 except instr_ready=1. alu_opcode=000. rst also resets the ALU stack.
- LOAD: instr_ready=1. On valid&ready, write {opcode,data} to buf[wr_ptr] and increment wr_ptr. An accept with instr_last=1, or an accept into slot PROG_DEPTH-1, goes to EXEC next cycle. result_overflow is cleared on the first accept.
- EXEC: instr_ready=0. Each cycle, decode buf[rd_ptr]:
  - illegal opcode -> ERROR, code 01.
  - push with depth==STACK_DEPTH -> ERROR, code 11.
  - add/mul with depth<2, or pop with depth<1 -> ERROR, code 10.
  - otherwise drive alu_opcode/alu_input_data for exactly one cycle and update depth: push +1, add/mul -1, pop -1.
  - push: advance to the next instruction next cycle, so back-to-back pushes issue at 1/cycle.
  - add/mul/pop: go to CAPTURE.
- CAPTURE: alu_opcode=000. Wait ALU_LAT cycles, then latch result_data=alu_output_data. For add/mul only, OR alu_overflow into result_overflow.
- After the last instruction is issued (and its CAPTURE, if any, completes) -> DONE. If the program ends on a push, result_data = the pushed value.
- DONE: result_valid=1, held stable until result_ready. On the handshake cycle, clear result_valid, reset pointers and go to LOAD. depth persists across programs because the ALU stack persists.
- ERROR: error=1, error_code held, alu idle, instr_ready=0. err_clr=1 -> LOAD with pointers reset; depth kept.
- Illegal instructions are never issued to the ALU.
- err_clr is ignored outside ERROR.

Optional Feature:
STACK_SEQ_STEP_EN:
- Defined: adds input step (1 bit). EXEC issues an instruction only on cycles with step=1 and otherwise holds with alu_opcode=000, for debug single-stepping.
- Undefined: the port is absent and EXEC issues every eligible cycle.

Decomposition:
- Package stack_alu_pkg:
  - opcode localparams OP_ADD=3'b100, OP_MUL=3'b101, OP_PUSH=3'b110, OP_POP=3'b111, OP_NOP=3'b000.
  - error code constants.
  - FSM state encoding.
- One sub-module, stack_seq_prog_buf: PROG_DEPTH x (3+N) register file with write port and combinational read.

Test Plan:
- Push 10, push 20, add(last) -> alu_opcode sequence 110,110,100. result_data=30, result_overflow=0, depth=1.
- Push 3, push 4, mul(last) -> result_data=12, result_overflow=0.
- Push 8'h7F, push 1, add(last) -> result_data=8'h80, result_overflow=1 held until result_ready.
- After reset, pop(last) -> error=1, error_code=10, alu_opcode stays 000. err_clr -> back to LOAD, instr_ready=1.
- Opcode 011 mid-program -> error_code=01, nothing issued. Separately, STACK_DEPTH+1 pushes -> error_code=11 on the extra push.
- rst asserted during CAPTURE -> all outputs return to reset values immediately. A new program of push 5 (last) then gives result_data=5.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// stack_alu_pkg -- shared constants and types for the stack ALU sequencer.
//   * ALU opcodes (3 bit) as seen on the instruction bus and the ALU port.
//   * Error codes reported on error_code.
//   * Sequencer FSM state encoding.
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_FULL      = 2'b11;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_EXEC,
        ST_CAPTURE,
        ST_DONE,
        ST_ERROR
    } seq_state_t;

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// stack_alu_sequencer_if -- instruction and result channels of the sequencer.
//   Instruction channel (valid/ready): instr_valid, instr_ready, instr_opcode,
//   instr_data, instr_last.
//   Result channel (valid/ready): result_valid, result_ready, result_data,
//   result_overflow.
//   master: the requester side (drives instructions, consumes results).
//   slave : the sequencer side.
interface stack_alu_sequencer_if #(
    parameter int N = 8
);
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   instr_opcode;
    logic [N-1:0] instr_data;
    logic         instr_last;

    logic         result_valid;
    logic         result_ready;
    logic [N-1:0] result_data;
    logic         result_overflow;

    modport master (
        output instr_valid, instr_opcode, instr_data, instr_last, result_ready,
        input  instr_ready, result_valid, result_data, result_overflow
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_data, instr_last, result_ready,
        output instr_ready, result_valid, result_data, result_overflow
    );
endinterface

// File: rtl/stack_seq_prog_buf.sv
// stack_seq_prog_buf -- program buffer, PROG_DEPTH entries of {opcode, data}.
//   clk              : write clock
//   we, waddr        : write enable / slot
//   wr_op, wr_data   : instruction written
//   raddr            : read slot (combinational read)
//   rd_op, rd_data   : instruction at raddr
module stack_seq_prog_buf #(
    parameter int N          = 8,
    parameter int PROG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(PROG_DEPTH)-1:0] waddr,
    input  logic [2:0]                    wr_op,
    input  logic [N-1:0]                  wr_data,
    input  logic [$clog2(PROG_DEPTH)-1:0] raddr,
    output logic [2:0]                    rd_op,
    output logic [N-1:0]                  rd_data
);
    logic [2:0]   op_mem   [PROG_DEPTH];
    logic [N-1:0] data_mem [PROG_DEPTH];

    // NOTE: storage is deliberately not reset; every slot is written before
    // the sequencer reads it, and a reset would turn the array into flops.
    always_ff @(posedge clk) begin
        if (we) begin
            op_mem[waddr]   <= wr_op;
            data_mem[waddr] <= wr_data;
        end
    end

    assign rd_op   = op_mem[raddr];
    assign rd_data = data_mem[raddr];
endmodule

// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer -- buffers a short RPN program and issues it to a
// stack ALU one instruction at a time, tracking stack depth so underflow and
// stack-full are caught before they reach the ALU.
//   clk, rst        : clock, asynchronous active-high reset
//   step            : (only with STACK_SEQ_STEP_EN) issue enable for single-step
//   bus (slave)     : instruction channel in, result channel out
//   busy            : high while executing (EXEC/CAPTURE)
//   error           : sticky error, error_code says why
//   err_clr         : leaves ERROR back to LOAD
//   alu_opcode      : opcode to ALU, OP_NOP when idle
//   alu_input_data  : push operand to ALU
//   alu_output_data : ALU result
//   alu_overflow    : ALU overflow flag
// Build option: define STACK_SEQ_STEP_EN to add the step input.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int N           = 8,
    parameter int PROG_DEPTH  = 8,
    parameter int STACK_DEPTH = 16,
    parameter int ALU_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef STACK_SEQ_STEP_EN
    input  logic                  step,
`endif
    stack_alu_sequencer_if.slave  bus,
    output logic                  busy,
    output logic                  error,
    output logic [1:0]            error_code,
    input  logic                  err_clr,
    output logic [2:0]            alu_opcode,
    output logic [N-1:0]          alu_input_data,
    input  logic [N-1:0]          alu_output_data,
    input  logic                  alu_overflow
);
    localparam int PTR_W   = $clog2(PROG_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int CNT_W   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t       state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, last_idx;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0] cap_cnt;
    logic             cap_last;    // instruction in CAPTURE ends the program
    logic             cap_arith;   // instruction in CAPTURE is add/mul
    logic [N-1:0]     result_q;
    logic             result_ovf_q;
    logic [1:0]       err_q;

    logic [2:0]       cur_op;
    logic [N-1:0]     cur_data;
    logic             accept, load_end, exec_go, issue, cap_done, cur_is_last;
    logic             is_push, is_arith, is_pop, is_illegal, step_ok;
    logic [1:0]       exec_err;

    stack_seq_prog_buf #(.N(N), .PROG_DEPTH(PROG_DEPTH)) u_prog_buf (
        .clk     (clk),
        .we      (accept),
        .waddr   (wr_ptr),
        .wr_op   (bus.instr_opcode),
        .wr_data (bus.instr_data),
        .raddr   (rd_ptr),
        .rd_op   (cur_op),
        .rd_data (cur_data)
    );

`ifdef STACK_SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign accept      = (state == ST_LOAD) && bus.instr_valid;
    // The program ends on an explicit last or when the buffer is full.
    assign load_end    = accept && (bus.instr_last || wr_ptr == PTR_W'(PROG_DEPTH - 1));
    assign exec_go     = (state == ST_EXEC) && step_ok;
    assign cur_is_last = (rd_ptr == last_idx);
    assign cap_done    = (cap_cnt == CNT_W'(ALU_LAT - 1));

    assign is_push    = (cur_op == OP_PUSH);
    assign is_pop     = (cur_op == OP_POP);
    assign is_arith   = (cur_op == OP_ADD) || (cur_op == OP_MUL);
    assign is_illegal = !(is_push || is_pop || is_arith);

    // Checks are ordered: an illegal opcode wins over any depth problem.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        exec_err = ERR_NONE;
        if (is_illegal)
            exec_err = ERR_ILLEGAL;
        else if (is_push && depth == DEPTH_W'(STACK_DEPTH))
            exec_err = ERR_FULL;
        else if ((is_arith && depth < DEPTH_W'(2)) || (is_pop && depth == '0))
            exec_err = ERR_UNDERFLOW;
    end

    assign issue = exec_go && (exec_err == ERR_NONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:    if (load_end) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (exec_go) begin
                    if (exec_err != ERR_NONE) state_nxt = ST_ERROR;
                    else if (!is_push)        state_nxt = ST_CAPTURE;
                    else if (cur_is_last)     state_nxt = ST_DONE;
                end
            end
            ST_CAPTURE: if (cap_done) state_nxt = cap_last ? ST_DONE : ST_EXEC;
            ST_DONE:    if (bus.result_ready) state_nxt = ST_LOAD;
            ST_ERROR:   if (err_clr) state_nxt = ST_LOAD;
            default:    state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.instr_ready     = (state == ST_LOAD);
        bus.result_valid    = (state == ST_DONE);
        bus.result_data     = result_q;
        bus.result_overflow = result_ovf_q;
        busy                = (state == ST_EXEC) || (state == ST_CAPTURE);
        error               = (state == ST_ERROR);
        error_code          = err_q;
        alu_opcode          = issue ? cur_op : OP_NOP;
        alu_input_data      = (issue && is_push) ? cur_data : '0;
    end

    // Datapath: pointers, stack depth, capture bookkeeping, result and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            last_idx     <= '0;
            depth        <= '0;
            cap_cnt      <= '0;
            cap_last     <= 1'b0;
            cap_arith    <= 1'b0;
            result_q     <= '0;
            result_ovf_q <= 1'b0;
            err_q        <= ERR_NONE;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (wr_ptr == '0) result_ovf_q <= 1'b0;
                        if (load_end)     last_idx     <= wr_ptr;
                    end
                end
                ST_EXEC: begin
                    if (exec_go && exec_err != ERR_NONE) err_q <= exec_err;
                    if (issue) begin
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        cap_last  <= cur_is_last;
                        cap_arith <= is_arith;
                        cap_cnt   <= '0;
                        if (is_push) begin
                            depth    <= depth + DEPTH_W'(1);
                            // A program ending on a push reports the pushed value.
                            result_q <= cur_data;
                        end else begin
                            depth <= depth - DEPTH_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    cap_cnt <= cap_cnt + CNT_W'(1);
                    if (cap_done) begin
                        result_q <= alu_output_data;
                        if (cap_arith) result_ovf_q <= result_ovf_q | alu_overflow;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ready) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                ST_ERROR: begin
                    if (err_clr) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        err_q  <= ERR_NONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
